pipeline_stage0_fetch: RTL

Instruction fetch stage. It produces the opcode byte consumed on Pipeline Stage 1's PipeIn, and it honours Stage 1's Pipe1Out_15_FetchSurpress. It owns the program counter, drives the instruction memory read handshake, yields the bus to DMA via BusRequest/BusGrant, and injects NOP bubbles whenever no valid opcode is available. It sits between instruction memory and PipelineStage1.

---
 rtl/cpu_pipe_pkg.sv | 17 +
 rtl/fetch_pc_reg.sv | 39 +++
 rtl/pipeline_stage0_fetch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stages.
//   NOP_OPCODE_DEFAULT : bubble byte injected when no valid opcode is available
//   PC_WIDTH_DEFAULT   : default program counter / instruction address width
//   fetch_state_e      : fetch stage state encoding
package cpu_pipe_pkg;

    localparam int         PC_WIDTH_DEFAULT   = 16;
    localparam logic [7:0] NOP_OPCODE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_FETCH   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_BUSHELD = 2'd3
    } fetch_state_e;

endpackage : cpu_pipe_pkg

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset (PC -> RESET_VECTOR)
//   load        : load load_addr (highest priority)
//   load_addr   : new PC value
//   inc         : advance PC by one, wrapping modulo 2^PC_WIDTH
//   pc          : current PC
module fetch_pc_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_r;

    // PC register: load beats increment; the add wraps naturally at PC_WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_VECTOR;
        end else if (load) begin
            pc_r <= load_addr;
        end else if (inc) begin
            pc_r <= pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule : fetch_pc_reg

// File: rtl/pipeline_stage0_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory read,
// yields the bus to DMA and feeds opcodes (or NOP bubbles) to Stage 1.
// Ports:
//   ClockIn, Reset_n        : clock, asynchronous active-low reset
//   FetchSurpress           : Stage 1 asks to skip this cycle's fetch
//   BusRequest / BusGrant   : DMA bus request / fetch unit has released the bus
//   PCLoad / PCLoadAddr     : redirect from a later stage
//   MemAddr/MemRead/MemData/MemReady : instruction memory read handshake
//   PipeOut / PCOut         : registered opcode and its address
module pipeline_stage0_fetch
    import cpu_pipe_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}},
    parameter logic [7:0]          NOP_OPCODE   = NOP_OPCODE_DEFAULT
) (
    input  logic                ClockIn,
    input  logic                Reset_n,
    input  logic                FetchSurpress,
    input  logic                BusRequest,
    output logic                BusGrant,
    input  logic                PCLoad,
    input  logic [PC_WIDTH-1:0] PCLoadAddr,
    output logic [PC_WIDTH-1:0] MemAddr,
    output logic                MemRead,
    input  logic [7:0]          MemData,
    input  logic                MemReady,
    output logic [7:0]          PipeOut,
    output logic [PC_WIDTH-1:0] PCOut
);

    fetch_state_e        state_r;
    logic [7:0]          pipe_r;
    logic [PC_WIDTH-1:0] pcout_r;
    logic                grant_r;
    logic [PC_WIDTH-1:0] pc_s;
    logic                pc_load_s;
    logic                capture_s;

    fetch_pc_reg #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk       (ClockIn),
        .rst_n     (Reset_n),
        .load      (pc_load_s),
        .load_addr (PCLoadAddr),
        .inc       (capture_s),
        .pc        (pc_s)
    );

    // Decide whether this edge loads the PC or captures a fetched opcode.
    always_comb begin
        pc_load_s = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (PCLoad) begin
                    pc_load_s = 1'b1;
                end else if (BusRequest || FetchSurpress) begin
                    capture_s = 1'b0;
                end else begin
                    capture_s = MemReady;
                end
            end
            ST_MEMWAIT: begin
                // Bus requests are ignored while an access is outstanding.
                if (PCLoad) begin
                    pc_load_s = 1'b1;
                end else if (FetchSurpress) begin
                    capture_s = 1'b0;
                end else begin
                    capture_s = MemReady;
                end
            end
            ST_BUSHELD: begin
                pc_load_s = PCLoad;
            end
            default: begin
                pc_load_s = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    // Fetch FSM with registered pipe byte, opcode address and bus grant.
    always_ff @(posedge ClockIn or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_RST;
            pipe_r  <= NOP_OPCODE;
            pcout_r <= RESET_VECTOR;
            grant_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RST: begin
                    state_r <= ST_FETCH;
                    pipe_r  <= NOP_OPCODE;
                    grant_r <= 1'b0;
                end
                ST_FETCH: begin
                    if (PCLoad) begin
                        pipe_r  <= NOP_OPCODE;
                        state_r <= ST_FETCH;
                    end else if (BusRequest) begin
                        pipe_r  <= NOP_OPCODE;
                        grant_r <= 1'b1;
                        state_r <= ST_BUSHELD;
                    end else if (FetchSurpress) begin
                        pipe_r  <= NOP_OPCODE;
                        state_r <= ST_FETCH;
                    end else if (MemReady) begin
                        pipe_r  <= MemData;
                        pcout_r <= pc_s;
                        state_r <= ST_FETCH;
                    end else begin
                        pipe_r  <= NOP_OPCODE;
                        state_r <= ST_MEMWAIT;
                    end
                end
                ST_MEMWAIT: begin
                    if (PCLoad) begin
                        // Outstanding access abandoned; its data is dropped.
                        pipe_r  <= NOP_OPCODE;
                        state_r <= ST_FETCH;
                    end else if (FetchSurpress) begin
                        pipe_r  <= NOP_OPCODE;
                        state_r <= ST_MEMWAIT;
                    end else if (MemReady) begin
                        pipe_r  <= MemData;
                        pcout_r <= pc_s;
                        state_r <= ST_FETCH;
                    end else begin
                        pipe_r  <= NOP_OPCODE;
                        state_r <= ST_MEMWAIT;
                    end
                end
                ST_BUSHELD: begin
                    pipe_r <= NOP_OPCODE;
                    if (PCLoad || !BusRequest) begin
                        grant_r <= 1'b0;
                        state_r <= ST_FETCH;
                    end else begin
                        grant_r <= 1'b1;
                        state_r <= ST_BUSHELD;
                    end
                end
                default: begin
                    state_r <= ST_RST;
                    pipe_r  <= NOP_OPCODE;
                    grant_r <= 1'b0;
                end
            endcase
        end
    end

    assign MemRead  = ((state_r == ST_FETCH) || (state_r == ST_MEMWAIT))
                      && !FetchSurpress && !PCLoad;
    assign MemAddr  = pc_s;
    assign PipeOut  = pipe_r;
    assign PCOut    = pcout_r;
    assign BusGrant = grant_r;

endmodule : pipeline_stage0_fetch
